mem_read_arbiter: RTL

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

---
 rtl/mem_read_arbiter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_read_arbiter.sv
// Round-robin read arbiter: drains per-memory entry counts into one merged stream.
// Optional build macro TRUNC_COUNT_EN enables the saturating truncated-window counter.
`ifndef MEM_SIZE
`define MEM_SIZE 6
`endif

module mem_read_arbiter #(
  parameter int NMEM       = 4,
  parameter int MEM_WIDTH  = 16,
  parameter int ADD_SIZE   = `MEM_SIZE,
  parameter int MAX_CYCLES = 100
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en_proc,
  input  logic [1:0]                   start,
  output logic [1:0]                   done,
  input  logic [NMEM*6-1:0]            number_in,
  output logic [NMEM-1:0]              read_en,
  output logic [NMEM*(ADD_SIZE+1)-1:0] read_add,
  input  logic [NMEM*MEM_WIDTH-1:0]    data_in,
  output logic [MEM_WIDTH-1:0]         data_out,
  output logic                         valid_out,
  output logic [2:0]                   src_out,
  output logic                         trunc,
  output logic [15:0]                  trunc_count
);

`ifdef TRUNC_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int AW = ADD_SIZE + 1;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, FIN} state_t;

  state_t                state_q, state_d;
  logic [2:0]            rr_q, rr_d;
  logic [5:0]            rd_cnt_q [NMEM];
  logic [5:0]            rd_cnt_d [NMEM];
  logic [5:0]            snap_q [NMEM];
  logic [5:0]            snap_d [NMEM];
  logic [AW-1:0]         add_q [NMEM];
  logic [AW-1:0]         add_d [NMEM];
  logic                  page_q, page_d;
  logic [15:0]           cyc_q, cyc_d;
  logic                  flush_q, flush_d;
  logic [NMEM-1:0]       read_en_q, read_en_d;
  logic                  v0_q, v0_d;
  logic [2:0]            src0_q, src0_d;
  logic                  valid_q, valid_d;
  logic [MEM_WIDTH-1:0]  data_q, data_d;
  logic [2:0]            src_q, src_d;
  logic [1:0]            done_q, done_d;
  logic                  trunc_q, trunc_d;
  logic [15:0]           tcnt_q, tcnt_d;

  logic [NMEM-1:0]       pending;
  logic                  found;
  logic [2:0]            gnt;
  logic                  rem_next;
  logic                  trunc_evt;

  always_comb begin
    for (int m = 0; m < NMEM; m++) pending[m] = rd_cnt_q[m] < snap_q[m];
  end

  // First pending memory at or after rr, wrapping.
  always_comb begin : grant_logic
    int idx;
    idx   = 0;
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < NMEM; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NMEM) idx = idx - NMEM;
      for (int m = 0; m < NMEM; m++) begin
        if (!found && pending[m] && idx == m) begin
          found = 1'b1;
          gnt   = 3'(m);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    page_d    = page_q;
    cyc_d     = cyc_q;
    flush_d   = flush_q;
    read_en_d = read_en_q;
    v0_d      = v0_q;
    src0_d    = src0_q;
    valid_d   = valid_q;
    data_d    = data_q;
    src_d     = src_q;
    done_d    = done_q;
    trunc_d   = trunc_q;
    rem_next  = 1'b0;
    trunc_evt = 1'b0;
    for (int m = 0; m < NMEM; m++) begin
      rd_cnt_d[m] = rd_cnt_q[m];
      snap_d[m]   = snap_q[m];
      add_d[m]    = add_q[m];
    end

    if (en_proc) begin
      read_en_d = '0;
      done_d    = 2'b00;
      v0_d      = |read_en_q;
      src0_d    = '0;
      for (int m = 0; m < NMEM; m++) if (read_en_q[m]) src0_d = 3'(m);
      valid_d = v0_q;
      if (v0_q) begin
        src_d = src0_q;
        for (int m = 0; m < NMEM; m++)
          if (src0_q == 3'(m)) data_d = data_in[m*MEM_WIDTH +: MEM_WIDTH];
      end

      if (start[0]) begin
        // A restart abandons the current window; in-flight reads still drain.
        if (state_q == SCAN) begin
          trunc_d   = |pending;
          trunc_evt = |pending;
        end
        for (int m = 0; m < NMEM; m++) begin
          snap_d[m]   = number_in[m*6 +: 6];
          rd_cnt_d[m] = '0;
        end
        page_d  = start[1];
        cyc_d   = '0;
        state_d = SCAN;
      end else begin
        case (state_q)
          SCAN: begin
            if (found) begin
              for (int m = 0; m < NMEM; m++) begin
                if (gnt == 3'(m)) begin
                  read_en_d[m] = 1'b1;
                  add_d[m]     = {page_q, ADD_SIZE'(rd_cnt_q[m])};
                  rd_cnt_d[m]  = rd_cnt_q[m] + 6'd1;
                end
              end
              rr_d = (gnt == 3'(NMEM-1)) ? 3'd0 : gnt + 3'd1;
            end
            cyc_d = cyc_q + 16'd1;
            for (int m = 0; m < NMEM; m++) if (rd_cnt_d[m] < snap_q[m]) rem_next = 1'b1;
            if (!rem_next) begin
              state_d = FLUSH;
              flush_d = 1'b1;
              trunc_d = 1'b0;
            end else if (cyc_d >= 16'(MAX_CYCLES)) begin
              state_d   = FLUSH;
              flush_d   = 1'b1;
              trunc_d   = 1'b1;
              trunc_evt = 1'b1;
            end
          end
          FLUSH: begin
            if (flush_q) flush_d = 1'b0;
            else begin
              state_d = FIN;
              done_d  = {page_q, 1'b1};
            end
          end
          FIN:     state_d = IDLE;
          default: state_d = state_q;
        endcase
      end
    end

    tcnt_d = tcnt_q;
    if (CNT_EN && trunc_evt && tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      page_q    <= 1'b0;
      cyc_q     <= '0;
      flush_q   <= 1'b0;
      read_en_q <= '0;
      v0_q      <= 1'b0;
      src0_q    <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      src_q     <= '0;
      done_q    <= '0;
      trunc_q   <= 1'b0;
      tcnt_q    <= '0;
      for (int m = 0; m < NMEM; m++) begin
        rd_cnt_q[m] <= '0;
        snap_q[m]   <= '0;
        add_q[m]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      page_q    <= page_d;
      cyc_q     <= cyc_d;
      flush_q   <= flush_d;
      read_en_q <= read_en_d;
      v0_q      <= v0_d;
      src0_q    <= src0_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      src_q     <= src_d;
      done_q    <= done_d;
      trunc_q   <= trunc_d;
      tcnt_q    <= tcnt_d;
      for (int m = 0; m < NMEM; m++) begin
        rd_cnt_q[m] <= rd_cnt_d[m];
        snap_q[m]   <= snap_d[m];
        add_q[m]    <= add_d[m];
      end
    end
  end

  // A pending grant is held, not lost, while the block is frozen.
  assign read_en = read_en_q & {NMEM{en_proc}};

  always_comb begin
    read_add = '0;
    for (int m = 0; m < NMEM; m++) read_add[m*AW +: AW] = add_q[m];
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign src_out     = src_q;
  assign done        = done_q;
  assign trunc       = trunc_q;
  assign trunc_count = tcnt_q;

endmodule
